digit_lock_ctrl: RTL and testbench

Parametrised digit-entry lock controller, the next generation of our lab password FSM. It generalises digit width and digit count, and it adds a handshake-qualified entry strobe, an attempt limit with timed lockout, and a password change that is only allowed while unlocked. It sits between the debounced switch/key front end and the LED/7-segment display logic.

---
 rtl/digit_lock_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_digit_lock_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/digit_lock_ctrl.sv
// digit_lock_ctrl: parametrised digit-entry lock controller.
// Stores a NUM_DIGITS x DIGIT_W password (entered MSB digit first),
// checks guesses against it, limits consecutive wrong guesses to MAX_TRIES,
// and follows the last allowed miss with a timed LOCKOUT of LOCKOUT_CYCLES.
// The password can only be changed while OPEN, and the change is atomic.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   set_req           request a new password (IDLE or OPEN)
//   lock_req          relock while OPEN (set_req has priority)
//   digit_valid       one digit capture per high cycle
//   digit_in          digit value
//   state             IDLE=0 SET=1 ARMED=2 GUESS=3 CHECK=4 OPEN=5 FAIL=6 LOCKOUT=7
//   password_set      a complete password is stored
//   unlocked          high in OPEN
//   fail              high for the single FAIL cycle
//   alarm             high in LOCKOUT
//   tries_left        remaining guesses before lockout
//   digit_count       digits captured in the current entry
//   dis_password      stored password while OPEN, zero otherwise
module digit_lock_ctrl #(
  parameter int unsigned DIGIT_W        = 4,
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               set_req,
  input  logic                               lock_req,
  input  logic                               digit_valid,
  input  logic [DIGIT_W-1:0]                 digit_in,
  output logic [2:0]                         state,
  output logic                               password_set,
  output logic                               unlocked,
  output logic                               fail,
  output logic                               alarm,
  output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left,
  output logic [$clog2(NUM_DIGITS+1)-1:0]    digit_count,
  output logic [DIGIT_W*NUM_DIGITS-1:0]      dis_password
);

  localparam int unsigned PW_W  = DIGIT_W * NUM_DIGITS;
  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int unsigned LCK_W = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SET     = 3'd1;
  localparam logic [2:0] S_ARMED   = 3'd2;
  localparam logic [2:0] S_GUESS   = 3'd3;
  localparam logic [2:0] S_CHECK   = 3'd4;
  localparam logic [2:0] S_OPEN    = 3'd5;
  localparam logic [2:0] S_FAIL    = 3'd6;
  localparam logic [2:0] S_LOCKOUT = 3'd7;

  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_DIGITS - 1);
  localparam logic [TRY_W-1:0] TRIES_MAX = TRY_W'(MAX_TRIES);
  localparam logic [LCK_W-1:0] LCK_LOAD  = LCK_W'(LOCKOUT_CYCLES - 1);

  logic [2:0]       state_q,  state_d;
  logic [PW_W-1:0]  pw_q,     pw_d;
  logic [PW_W-1:0]  shadow_q, shadow_d;
  logic [PW_W-1:0]  guess_q,  guess_d;
  logic             pset_q,   pset_d;
  logic [TRY_W-1:0] tries_q,  tries_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [LCK_W-1:0] lck_q,    lck_d;

  // Place digit d at position idx, position 0 being the most significant digit.
  function automatic logic [PW_W-1:0] put_digit(input logic [PW_W-1:0]    vec,
                                                input logic [CNT_W-1:0]   idx,
                                                input logic [DIGIT_W-1:0] d);
    logic [PW_W-1:0] r;
    r = vec;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == CNT_W'(k)) r[PW_W-1-k*DIGIT_W -: DIGIT_W] = d;
    end
    return r;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pw_q     <= '0;
      shadow_q <= '0;
      guess_q  <= '0;
      pset_q   <= 1'b0;
      tries_q  <= TRIES_MAX;
      count_q  <= '0;
      lck_q    <= '0;
    end else begin
      state_q  <= state_d;
      pw_q     <= pw_d;
      shadow_q <= shadow_d;
      guess_q  <= guess_d;
      pset_q   <= pset_d;
      tries_q  <= tries_d;
      count_q  <= count_d;
      lck_q    <= lck_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    pw_d     = pw_q;
    shadow_d = shadow_q;
    guess_d  = guess_q;
    pset_d   = pset_q;
    tries_d  = tries_q;
    count_d  = count_q;
    lck_d    = lck_q;

    case (state_q)
      S_IDLE: begin
        if (set_req) begin
          state_d = S_SET;
          count_d = '0;
        end
      end

      // New digits land in the shadow; the stored password only changes on completion.
      S_SET: begin
        if (digit_valid) begin
          shadow_d = put_digit(shadow_q, count_q, digit_in);
          if (count_q == LAST_IDX) begin
            pw_d    = shadow_d;
            pset_d  = 1'b1;
            tries_d = TRIES_MAX;
            count_d = '0;
            state_d = S_ARMED;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end

      S_ARMED: begin
        if (digit_valid) begin
          guess_d = put_digit(guess_q, '0, digit_in);
          if (NUM_DIGITS == 1) begin
            state_d = S_CHECK;
          end else begin
            count_d = CNT_W'(1);
            state_d = S_GUESS;
          end
        end
      end

      S_GUESS: begin
        if (digit_valid) begin
          guess_d = put_digit(guess_q, count_q, digit_in);
          if (count_q == LAST_IDX) begin
            count_d = '0;
            state_d = S_CHECK;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end

      S_CHECK: begin
        if (guess_q == pw_q) begin
          tries_d = TRIES_MAX;
          state_d = S_OPEN;
        end else if (tries_q > TRY_W'(1)) begin
          tries_d = tries_q - TRY_W'(1);
          state_d = S_FAIL;
        end else begin
          tries_d = '0;
          lck_d   = LCK_LOAD;
          state_d = S_LOCKOUT;
        end
      end

      S_FAIL: state_d = S_ARMED;

      // Counter is loaded with LOCKOUT_CYCLES-1 so the state lasts exactly LOCKOUT_CYCLES.
      S_LOCKOUT: begin
        if (lck_q == '0) begin
          tries_d = TRIES_MAX;
          state_d = S_ARMED;
        end else begin
          lck_d = lck_q - LCK_W'(1);
        end
      end

      S_OPEN: begin
        if (set_req) begin
          count_d = '0;
          state_d = S_SET;
        end else if (lock_req) begin
          state_d = S_ARMED;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registers only.
  assign state        = state_q;
  assign password_set = pset_q;
  assign unlocked     = (state_q == S_OPEN);
  assign fail         = (state_q == S_FAIL);
  assign alarm        = (state_q == S_LOCKOUT);
  assign tries_left   = tries_q;
  assign digit_count  = count_q;
  assign dis_password = (state_q == S_OPEN) ? pw_q : '0;

endmodule

// File: tb/tb_digit_lock_ctrl.sv
// tb_digit_lock_ctrl: directed bench for digit_lock_ctrl.
// Instance a uses default parameters; instance b uses DIGIT_W=8, NUM_DIGITS=2.
module tb_digit_lock_ctrl;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_set_req, a_lock_req, a_valid;
  logic [3:0]  a_digit;
  logic [2:0]  a_state;
  logic        a_pset, a_unlocked, a_fail, a_alarm;
  logic [1:0]  a_tries;
  logic [2:0]  a_count;
  logic [15:0] a_dis;

  logic        b_set_req, b_lock_req, b_valid;
  logic [7:0]  b_digit;
  logic [2:0]  b_state;
  logic        b_pset, b_unlocked, b_fail, b_alarm;
  logic [1:0]  b_tries;
  logic [1:0]  b_count;
  logic [15:0] b_dis;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  digit_lock_ctrl u_a (
    .clk(clk), .rst(rst), .set_req(a_set_req), .lock_req(a_lock_req),
    .digit_valid(a_valid), .digit_in(a_digit), .state(a_state),
    .password_set(a_pset), .unlocked(a_unlocked), .fail(a_fail), .alarm(a_alarm),
    .tries_left(a_tries), .digit_count(a_count), .dis_password(a_dis)
  );

  digit_lock_ctrl #(.DIGIT_W(8), .NUM_DIGITS(2)) u_b (
    .clk(clk), .rst(rst), .set_req(b_set_req), .lock_req(b_lock_req),
    .digit_valid(b_valid), .digit_in(b_digit), .state(b_state),
    .password_set(b_pset), .unlocked(b_unlocked), .fail(b_fail), .alarm(b_alarm),
    .tries_left(b_tries), .digit_count(b_count), .dis_password(b_dis)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_key(input logic [3:0] d);
    a_valid = 1'b1;
    a_digit = d;
    step();
    a_valid = 1'b0;
  endtask

  task automatic a_enter(input logic [15:0] v);
    a_key(v[15:12]);
    a_key(v[11:8]);
    a_key(v[7:4]);
    a_key(v[3:0]);
  endtask

  task automatic b_key(input logic [7:0] d);
    b_valid = 1'b1;
    b_digit = d;
    step();
    b_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_set_req = 0; a_lock_req = 0; a_valid = 0; a_digit = '0;
    b_set_req = 0; b_lock_req = 0; b_valid = 0; b_digit = '0;
    step();
    step();

    // Reset state
    chk("rst_state", a_state, 0);
    chk("rst_pset", a_pset, 0);
    chk("rst_tries", a_tries, 3);
    chk("rst_count", a_count, 0);
    chk("rst_dis", a_dis, 0);
    chk("rst_outs", {a_unlocked, a_fail, a_alarm}, 0);
    rst = 1'b0;
    step();

    // IDLE ignores digits
    a_key(4'h5);
    chk("idle_ign_state", a_state, 0);
    chk("idle_ign_count", a_count, 0);

    // Instance b: 2 x 8-bit digits, digit_valid held high two cycles while ARMED
    b_set_req = 1; step(); b_set_req = 0;
    chk("b_set", b_state, 1);
    b_key(8'h5A);
    chk("b_set_cnt", b_count, 1);
    b_key(8'hC3);
    chk("b_armed", b_state, 2);
    chk("b_pset", b_pset, 1);
    b_valid = 1; b_digit = 8'h5A; step();
    chk("b_guess", b_state, 3);
    b_digit = 8'hC3; step(); b_valid = 0;
    chk("b_check", b_state, 4);
    step();
    chk("b_open", b_state, 5);
    chk("b_dis", b_dis, 16'h5AC3);

    // Set password 1234 and unlock
    a_set_req = 1; step(); a_set_req = 0;
    chk("t1_set", a_state, 1);
    a_key(4'h1);
    chk("t1_cnt1", a_count, 1);
    a_key(4'h2); a_key(4'h3); a_key(4'h4);
    chk("t1_armed", a_state, 2);
    chk("t1_pset", a_pset, 1);
    chk("t1_tries", a_tries, 3);
    chk("t1_cnt0", a_count, 0);
    a_key(4'h1);
    chk("t1_guess", a_state, 3);
    chk("t1_gcnt", a_count, 1);
    a_key(4'h2); a_key(4'h3); a_key(4'h4);
    chk("t1_check", a_state, 4);
    chk("t1_chk_unl", a_unlocked, 0);
    step();
    chk("t1_open", a_state, 5);
    chk("t1_unl", a_unlocked, 1);
    chk("t1_dis", a_dis, 16'h1234);

    // Relock
    a_lock_req = 1; step(); a_lock_req = 0;
    chk("relock_state", a_state, 2);
    chk("relock_dis", a_dis, 0);

    // One wrong guess
    a_enter(16'h1235);
    chk("t2_check", a_state, 4);
    step();
    chk("t2_fail", a_fail, 1);
    chk("t2_fstate", a_state, 6);
    chk("t2_tries", a_tries, 2);
    step();
    chk("t2_fail_off", a_fail, 0);
    chk("t2_armed", a_state, 2);
    chk("t2_dis", a_dis, 0);

    // Two more misses lead to lockout
    a_enter(16'h1235); step(); step();
    chk("t3_tries1", a_tries, 1);
    a_enter(16'h0000); step();
    chk("t3_lock", a_state, 7);
    chk("t3_tries0", a_tries, 0);
    for (int i = 0; i < 16; i++) begin
      chk("t3_alarm", a_alarm, 1);
      a_set_req = (i < 15);
      a_valid   = (i < 15);
      a_digit   = 4'h1;
      step();
    end
    a_set_req = 0; a_valid = 0;
    chk("t3_after_state", a_state, 2);
    chk("t3_after_alarm", a_alarm, 0);
    chk("t3_after_tries", a_tries, 3);
    chk("t3_after_cnt", a_count, 0);
    a_enter(16'h1234); step();
    chk("t3_open", a_state, 5);

    // set_req beats lock_req; reset mid-entry clears everything
    a_set_req = 1; a_lock_req = 1; step(); a_set_req = 0; a_lock_req = 0;
    chk("t4_set", a_state, 1);
    chk("t4_pset_kept", a_pset, 1);
    a_key(4'h9); a_key(4'h8);
    chk("t4_cnt", a_count, 2);
    rst = 1'b1;
    #2;
    chk("t4_rst_state", a_state, 0);
    chk("t4_rst_pset", a_pset, 0);
    chk("t4_rst_cnt", a_count, 0);
    chk("t4_rst_tries", a_tries, 3);
    rst = 1'b0;
    step();

    // Password change from OPEN
    a_set_req = 1; step(); a_set_req = 0;
    a_enter(16'h1234);
    a_enter(16'h1234); step();
    chk("t5_open", a_state, 5);
    a_set_req = 1; step(); a_set_req = 0;
    chk("t5_set", a_state, 1);
    a_enter(16'hABCD);
    chk("t5_armed", a_state, 2);
    chk("t5_pset", a_pset, 1);
    a_enter(16'h1234); step();
    chk("t5_old_fail", a_fail, 1);
    chk("t5_tries", a_tries, 2);
    step();
    a_enter(16'hABCD); step();
    chk("t5_new_open", a_state, 5);
    chk("t5_dis", a_dis, 16'hABCD);
    chk("t5_tries_rst", a_tries, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
